// File: rtl/wb_initiator_bridge_if.sv
// Signal bundle between a local command/response user and the Wishbone initiator bridge.
// The master modport is the bridge side. The slave modport is the user/peripheral side.
interface wb_initiator_bridge_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [3:0]  cmd_sel_i;
  logic [31:0] cmd_dat_i;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_sts_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, rsp_ready_i,
    output cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    output wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_dat_o, rsp_sts_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, rsp_ready_i,
    input  cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    input  wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_dat_o, rsp_sts_o
  );
endinterface

// File: rtl/wb_initiator_bridge.sv
// Wishbone classic single-transfer initiator: one accepted command becomes one bus cycle.
// Each bus cycle ends with a single response carrying the data and the status.
module wb_initiator_bridge #(
  parameter int TIMEOUT = 255,
  parameter int TMR_W   = 8
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_ni,
  wb_initiator_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;
  logic [1:0]        rsp_sts_q, rsp_sts_d;
  logic              done;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      timer_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_sts_q   <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      timer_q     <= timer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_sts_q   <= rsp_sts_d;
    end
  end

  // Termination priority in BUS: error beats ack, and ack beats timeout.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    timer_d     = timer_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_sts_d   = rsp_sts_q;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d    = bus.cmd_we_i;
          sel_d   = bus.cmd_sel_i;
          adr_d   = bus.cmd_adr_i & ~32'h3;
          dat_d   = bus.cmd_dat_i;
          cyc_d   = 1'b1;
          timer_d = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus.wbm_err_i) begin
          rsp_sts_d = 2'b01;
          rsp_dat_d = '0;
          done      = 1'b1;
        end else if (bus.wbm_ack_i) begin
          rsp_sts_d = 2'b00;
          rsp_dat_d = we_q ? 32'h0 : bus.wbm_dat_i;
          done      = 1'b1;
        end else if (TMO_EN && timer_q == TMR_LAST) begin
          rsp_sts_d = 2'b10;
          rsp_dat_d = '0;
          done      = 1'b1;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
        if (done) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = cyc_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_sel_o   = sel_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.rsp_sts_o   = rsp_sts_q;

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Directed bench for wb_initiator_bridge.
// Expected responses are queued when a command is issued and compared when the response arrives.
module tb_wb_initiator_bridge;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_initiator_bridge_if bus ();

  wb_initiator_bridge #(.TIMEOUT(255), .TMR_W(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus.master)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  sts;
  } rsp_t;

  rsp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] dat, input logic [1:0] sts);
    rsp_t r;
    r.dat = dat;
    r.sts = sts;
    sb_q.push_back(r);
  endtask

  // Offer a command, let it be accepted, and return at the negedge after acceptance.
  task automatic apply_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_sel_i   = sel;
    bus.cmd_dat_i   = dat;
    check("cmd_ready_before_accept", 32'(bus.cmd_ready_o), 32'd1);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = ~we;
    bus.cmd_adr_i   = $urandom;
    bus.cmd_sel_i   = 4'($urandom);
    bus.cmd_dat_i   = $urandom;
    check("cmd_ready_in_bus", 32'(bus.cmd_ready_o), 32'd0);
  endtask

  task automatic bus_reply(input logic ack, input logic err, input logic [31:0] rdata);
    bus.wbm_ack_i = ack;
    bus.wbm_err_i = err;
    bus.wbm_dat_i = rdata;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    bus.wbm_dat_i = 32'hBAD0_BAD0;
  endtask

  task automatic wait_rsp(input string tag, input int max_cycles);
    int   n = 0;
    rsp_t exp;
    while (!bus.rsp_valid_o && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid_o) begin
      check({tag, "_rsp_valid_timeout"}, 32'(bus.rsp_valid_o), 32'd1);
    end else if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_rsp_dat"}, bus.rsp_dat_o, exp.dat);
      check({tag, "_rsp_sts"}, 32'(bus.rsp_sts_o), 32'(exp.sts));
      check({tag, "_cyc_in_resp"}, 32'(bus.wbm_cyc_o), 32'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check({tag, "_rsp_valid_cleared"}, 32'(bus.rsp_valid_o), 32'd0);
    check({tag, "_cmd_ready_idle"}, 32'(bus.cmd_ready_o), 32'd1);
  endtask

  initial begin
    int cnt;
    rst_n           = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.wbm_dat_i   = '0;
    bus.wbm_ack_i   = 1'b0;
    bus.wbm_err_i   = 1'b0;
    bus.rsp_ready_i = 1'b0;

    // Reset values
    #1;
    check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("rst_we", 32'(bus.wbm_we_o), 32'd0);
    check("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
    check("rst_adr", bus.wbm_adr_o, 32'd0);
    check("rst_dat_o", bus.wbm_dat_o, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_rsp_dat", bus.rsp_dat_o, 32'd0);
    check("rst_rsp_sts", 32'(bus.rsp_sts_o), 32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write with an ack one cycle after the strobe
    expect_rsp(32'h0, 2'b00);
    apply_cmd(1'b1, 32'h3000_0000, 4'b0011, 32'h0000_1234);
    check("wr_cyc", 32'(bus.wbm_cyc_o), 32'd1);
    check("wr_stb", 32'(bus.wbm_stb_o), 32'd1);
    check("wr_we", 32'(bus.wbm_we_o), 32'd1);
    check("wr_sel", 32'(bus.wbm_sel_o), 32'h3);
    check("wr_adr", bus.wbm_adr_o, 32'h3000_0000);
    check("wr_dat_o", bus.wbm_dat_o, 32'h0000_1234);
    bus_reply(1'b1, 1'b0, 32'hFFFF_FFFF);
    check("wr_cyc_dropped", 32'(bus.wbm_cyc_o), 32'd0);
    check("wr_stb_dropped", 32'(bus.wbm_stb_o), 32'd0);
    wait_rsp("wr", 4);

    // Read from an unaligned byte address
    expect_rsp(32'h0000_01FF, 2'b00);
    apply_cmd(1'b0, 32'h3000_0003, 4'b1111, 32'h5555_5555);
    check("rd_adr_aligned", bus.wbm_adr_o, 32'h3000_0000);
    check("rd_we", 32'(bus.wbm_we_o), 32'd0);
    bus_reply(1'b1, 1'b0, 32'h0000_01FF);
    wait_rsp("rd", 4);

    // No ack: the cycle must be aborted after exactly 255 cycles with cyc high
    expect_rsp(32'h0, 2'b10);
    apply_cmd(1'b0, 32'h3000_0010, 4'b1111, 32'h0);
    cnt = 0;
    while (bus.wbm_cyc_o && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_cyc_cycles", 32'(cnt), 32'd255);
    wait_rsp("tmo", 4);

    // The next command after a timeout completes normally
    expect_rsp(32'h0, 2'b00);
    apply_cmd(1'b1, 32'h3000_0004, 4'b1111, 32'hCAFE_F00D);
    check("post_tmo_dat_o", bus.wbm_dat_o, 32'hCAFE_F00D);
    bus_reply(1'b1, 1'b0, 32'h0);
    wait_rsp("post_tmo", 4);

    // Simultaneous ack and error: the error wins
    expect_rsp(32'h0, 2'b01);
    apply_cmd(1'b0, 32'h3000_0008, 4'b1111, 32'h0);
    bus_reply(1'b1, 1'b1, 32'hDEAD_BEEF);
    wait_rsp("ack_err", 4);

    // A spurious ack while idle must not start a response
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h1111_2222;
    repeat (3) @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    check("spurious_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("spurious_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("spurious_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

    // Response back-pressure: the fields stay stable and no new command is accepted
    expect_rsp(32'hA5A5_0001, 2'b00);
    apply_cmd(1'b0, 32'h3000_000C, 4'b1111, 32'h0);
    bus_reply(1'b1, 1'b0, 32'hA5A5_0001);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("bp_rsp_dat", bus.rsp_dat_o, 32'hA5A5_0001);
      check("bp_rsp_sts", 32'(bus.rsp_sts_o), 32'd0);
      check("bp_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
      check("bp_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      @(negedge clk);
    end
    bus.cmd_valid_i = 1'b0;
    wait_rsp("bp", 2);

    // Reset asserted while cyc is high
    apply_cmd(1'b1, 32'h3000_0020, 4'b1111, 32'h1);
    check("rstbus_cyc_before", 32'(bus.wbm_cyc_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstbus_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("rstbus_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("rstbus_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted while a response is pending
    apply_cmd(1'b0, 32'h3000_0024, 4'b1111, 32'h0);
    bus_reply(1'b1, 1'b0, 32'h7777_7777);
    check("rstrsp_valid_before", 32'(bus.rsp_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstrsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rstrsp_dat", bus.rsp_dat_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A clean transfer after reset
    expect_rsp(32'h0000_0042, 2'b00);
    apply_cmd(1'b0, 32'h3000_0028, 4'b0001, 32'h0);
    check("clean_adr", bus.wbm_adr_o, 32'h3000_0028);
    bus_reply(1'b1, 1'b0, 32'h0000_0042);
    wait_rsp("clean", 4);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
